// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// Parity selector, receiver FSM states and baud divisor rounding.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_ODD  = 2'd1,
      PAR_EVEN = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_WAIT_IDLE
   } rx_state_e;

   // Clock cycles per bit, rounded to nearest.
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count, full and empty flags.
// Latency: a write is visible at rd_dat the cycle after it is accepted.
// Backpressure: writes while full are ignored unless a read happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_dat,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_rd;
   logic             do_wr;

   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign do_rd  = rd_en && !empty;
   assign do_wr  = wr_en && (!full || do_rd);
   assign rd_dat = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         case ({do_wr, do_rd})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: bytes plus parity/framing status into a valid/ready FIFO.
// Latency: entry valid 1 cycle after the final stop sample (+1 with UART_RX_MAJORITY_EN).
// Backpressure: full FIFO drops the completed frame and pulses overrun for one cycle.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd,
   output logic [DATA_BITS-1:0]          m_data,
   output logic                          m_perr,
   output logic                          m_ferr,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          busy
);

   localparam int DIV   = calc_div(CLK_HZ, BAUD);
   localparam int TW    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W = $clog2(DATA_BITS);

   localparam logic [TW-1:0]    HALF_LOAD = TW'(DIV / 2 - 1);
   localparam logic [TW-1:0]    FULL_LOAD = TW'(DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
   localparam logic             PAR_EXP   = (PARITY == int'(PAR_ODD));
   localparam bit               HAS_PAR   = (PARITY != int'(PAR_NONE));
   localparam logic             STOP_LAST = (STOP_BITS == 2);

   logic                 rx_meta, rxs, rxs_prev;
   rx_state_e            state, state_n;
   logic [TW-1:0]        timer, timer_n;
   logic [IDX_W-1:0]     idx, idx_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 perr, perr_n;
   logic                 ferr, ferr_n, ferr_fin;
   logic                 stop_idx, stop_idx_n;
   logic                 active, expire, bit_tick, bit_val, push;
   logic [DATA_BITS+1:0] push_dat, head;
   logic                 fifo_full, fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         rx_meta  <= rxd;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
      end
   end

   assign active = (state == ST_START) || (state == ST_DATA) ||
                   (state == ST_PARITY) || (state == ST_STOP);
   assign expire = active && (timer == '0);

`ifdef UART_RX_MAJORITY_EN
   // Decide one cycle after expiry, voting over the samples around it.
   logic rxs_d2, pend;
   always_ff @(posedge clk) begin
      if (rst) begin
         rxs_d2 <= 1'b1;
         pend   <= 1'b0;
      end else begin
         rxs_d2 <= rxs_prev;
         pend   <= expire;
      end
   end
   assign bit_tick = pend;
   assign bit_val  = (rxs & rxs_prev) | (rxs & rxs_d2) | (rxs_prev & rxs_d2);
`else
   assign bit_tick = expire;
   assign bit_val  = rxs;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         timer    <= '0;
         idx      <= '0;
         shift    <= '0;
         perr     <= 1'b0;
         ferr     <= 1'b0;
         stop_idx <= 1'b0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         idx      <= idx_n;
         shift    <= shift_n;
         perr     <= perr_n;
         ferr     <= ferr_n;
         stop_idx <= stop_idx_n;
      end
   end

   always_comb begin
      state_n    = state;
      timer_n    = timer;
      idx_n      = idx;
      shift_n    = shift;
      perr_n     = perr;
      ferr_n     = ferr;
      stop_idx_n = stop_idx;
      ferr_fin   = ferr;
      push       = 1'b0;

      // Bit period is anchored to the expiry, independent of voting delay.
      if (active) timer_n = (timer == '0) ? FULL_LOAD : timer - TW'(1);

      case (state)
         ST_IDLE: begin
            if (rxs_prev && !rxs) begin
               state_n    = ST_START;
               timer_n    = HALF_LOAD;
               idx_n      = '0;
               perr_n     = 1'b0;
               ferr_n     = 1'b0;
               stop_idx_n = 1'b0;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               state_n = bit_val ? ST_IDLE : ST_DATA;
               idx_n   = '0;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               shift_n[idx] = bit_val;
               if (idx == LAST_IDX) state_n = HAS_PAR ? ST_PARITY : ST_STOP;
               else                 idx_n   = idx + IDX_W'(1);
            end
         end
         ST_PARITY: begin
            if (bit_tick) begin
               perr_n  = ((^shift) ^ bit_val) != PAR_EXP;
               state_n = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_tick) begin
               ferr_fin = ferr | ~bit_val;
               ferr_n   = ferr_fin;
               if (stop_idx == STOP_LAST) begin
                  push    = 1'b1;
                  state_n = bit_val ? ST_IDLE : ST_WAIT_IDLE;
               end else begin
                  stop_idx_n = 1'b1;
               end
            end
         end
         ST_WAIT_IDLE: begin
            if (rxs) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign push_dat = {ferr_fin, perr, shift};

   sync_fifo #(
      .WIDTH (DATA_BITS + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (push),
      .wr_dat (push_dat),
      .rd_en  (m_ready),
      .rd_dat (head),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   // A full FIFO is never empty, so a same-cycle pop is just m_ready.
   always_ff @(posedge clk) begin
      if (rst) overrun <= 1'b0;
      else     overrun <= push && fifo_full && !m_ready;
   end

   assign {m_ferr, m_perr, m_data} = head;
   assign m_valid = !fifo_empty;
   assign busy    = (state != ST_IDLE);

endmodule
